// File: rtl/exu_ctrl.sv
// rtl/exu_ctrl.sv - single-op execution-unit issue/completion controller (optional watchdog: EXU_CTRL_TIMEOUT_EN)
module exu_ctrl #(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cls,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             alu_start,
  output logic             mul_start,
  output logic             div_start,
  input  logic             alu_ok,
  input  logic             mul_ok,
  input  logic             div_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_cls,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state, state_nxt;
  logic             kill, kill_nxt;
  logic             first;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       cls_q;
  logic             accept;
  logic             sel_ok;
  logic             hon_ok;
  logic             timeout_hit;

  assign accept = in_valid && in_ready;

  // Completion pulse of the unit owning the captured class (class 3 runs on the ALU).
  always_comb begin
    sel_ok = 1'b0;
    case (cls_q)
      2'd1:    sel_ok = mul_ok;
      2'd2:    sel_ok = div_ok;
      default: sel_ok = alu_ok;
    endcase
  end

  // The unit cannot finish in the cycle it is started, so its ok is honoured only after that cycle.
  assign hon_ok = (state == WAIT) && !first && sel_ok;

`ifdef EXU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt;

  assign timeout_hit = (state == WAIT) && !hon_ok && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts WAIT cycles of the current op, restarted on every acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // One-cycle abort pulse, raised in the first IDLE cycle after the watchdog fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // State, kill flag and start-cycle marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      first <= accept;
    end
  end

  // Capture the op identity at acceptance; it stays stable until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      cls_q <= 2'd0;
    end else if (accept) begin
      tag_q <= in_tag;
      cls_q <= in_cls;
    end
  end

  // Next state and kill flag: a flush never aborts a running unit, it only discards its result.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          kill_nxt  = 1'b0;
        end
      end
      WAIT: begin
        if (hon_ok) begin
          state_nxt = (kill || flush) ? IDLE : HOLD;
          kill_nxt  = 1'b0;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          kill_nxt  = 1'b0;
        end else if (flush) begin
          kill_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (flush || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  // Handshake, start pulses and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    alu_start = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !flush;
      end
      WAIT: begin
        busy = 1'b1;
        if (first) begin
          case (cls_q)
            2'd1:    mul_start = 1'b1;
            2'd2:    div_start = 1'b1;
            default: alu_start = 1'b1;
          endcase
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign out_tag = tag_q;
  assign out_cls = cls_q;

endmodule

// File: doc/exu_ctrl.md
EXU_CTRL -- requirements
Module: exu_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5: width of the instruction tag.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 128: watchdog limit in WAIT cycles, used only with EXU_CTRL_TIMEOUT_EN.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  issue request from decode.
- in_ready  out  1  controller can accept an issue.
- in_cls  in  2  unit class: 0 ALU/BR, 1 MUL, 2 DIV, 3 treated as ALU.
- in_tag  in  TAG_W  instruction tag.
- flush  in  1  pipeline redirect; kills the in-flight op.
- alu_start, mul_start, div_start  out  1 each  one-cycle start pulses.
- alu_ok, mul_ok, div_ok  in  1 each  unit completion pulses.
- out_valid  out  1  result available to writeback.
- out_ready  in  1  writeback accepts the result.
- out_tag  out  TAG_W  tag of the completed op.
- out_cls  out  2  class of the completed op.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  watchdog abort pulse.

Function
REQ-004 SHALL implement the FSM states IDLE, WAIT and HOLD.
REQ-005 in_ready SHALL equal (state==IDLE && !flush); an issue is accepted on a clock edge where in_valid && in_ready.
REQ-006 On acceptance, the block SHALL register in_tag and in_cls, move to WAIT, and assert exactly one start pulse, for the captured class, during the first WAIT cycle only.
REQ-007 The latency from acceptance to the start pulse SHALL be one cycle; at most one op SHALL be in flight.
REQ-008 In WAIT, the ok of the selected unit SHALL be honoured from the cycle after the start pulse onward.
- The selected unit's ok during the start cycle SHALL be ignored.
- ok from non-selected units SHALL be ignored in every state.
REQ-009 In WAIT, a honoured ok with no pending kill SHALL move the FSM to HOLD; out_valid SHALL be 1 in HOLD, with out_tag and out_cls stable.
REQ-010 In HOLD, out_valid && out_ready SHALL return the FSM to IDLE on that edge; no new issue is accepted in the same cycle.
REQ-011 A flush during WAIT SHALL set a kill flag.
- The unit is not aborted.
- The later ok SHALL return the FSM to IDLE with no out_valid, and SHALL clear the kill flag.
- A flush coincident with ok SHALL also discard the result.
REQ-012 A flush during HOLD SHALL return the FSM to IDLE on the next edge, dropping out_valid; flush has precedence over out_ready.
REQ-013 A flush during IDLE SHALL block acceptance for that cycle only.
REQ-014 busy SHALL be 1 in WAIT and in HOLD.

Reset
REQ-015 rst SHALL asynchronously force state=IDLE and kill=0, with all outputs as follows:
- in_ready=1 whenever flush=0.
- start pulses=0, out_valid=0, busy=0, timeout_err=0.
- out_tag=0, out_cls=0, watchdog counter=0.
REQ-016 A reset during WAIT or HOLD SHALL discard the op; any ok arriving after reset is released SHALL be ignored.

Configuration
REQ-017 With EXU_CTRL_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- If TIMEOUT_CYC WAIT cycles elapse without a honoured ok, the FSM SHALL go to IDLE, pulse timeout_err for one cycle, and not assert out_valid.
- A late ok after a timeout SHALL be ignored.
REQ-018 Without EXU_CTRL_TIMEOUT_EN, there SHALL be no counter, timeout_err SHALL be tied to 0, and WAIT SHALL persist until a honoured ok arrives.

Verification
REQ-019 ALU issue (cls=0, tag=3); alu_ok one cycle after alu_start; out_ready=1 -> alu_start pulses once, then out_valid=1 with tag=3, then IDLE.
REQ-020 DIV issue (tag=7); div_ok 64 cycles after start; out_ready held 0 for 5 cycles -> out_valid stays high with tag=7 for 6 cycles; in_ready=0 throughout.
REQ-021 MUL issue; flush 2 cycles after start; mul_ok on cycle 4 -> no out_valid; FSM in IDLE the cycle after mul_ok.
REQ-022 ALU issue; spurious mul_ok and div_ok during WAIT -> no state change; completion only on alu_ok.
REQ-023 DIV issue; rst asserted mid-WAIT; div_ok after release -> all outputs at reset values, no out_valid.
REQ-024 With EXU_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16: MUL issue, no mul_ok -> timeout_err is a single-cycle pulse after 16 WAIT cycles, FSM returns to IDLE, a late mul_ok is ignored.
